// File: rtl/sys_defs.sv
// Shared definitions for the fetch/decode pipeline slice.
//   NOOP_INST     : instruction word presented to decode when no real
//                   instruction is available (RISC-V addi x0, x0, 0).
//   fetch_entry_t : one captured fetch result {pc, npc, ir}.
package sys_defs;

    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Pointer and occupancy control for the fetch queue.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   valid_inst      : fetch is presenting a real instruction
//   take_branch     : taken branch this cycle; flushes the queue
//   id_stall        : decode cannot consume the head this cycle
//   push, pop       : decoded enqueue / dequeue strobes for this cycle
//   full, empty     : occupancy flags from the registered count
//   wr_ptr, rd_ptr  : circular write / read indices
//   count           : current occupancy, 0..DEPTH
module fq_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_inst,
    input  logic                       take_branch,
    input  logic                       id_stall,
    output logic                       push,
    output logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push is refused whenever the queue is full, even if a pop frees a
    // slot in the same cycle; a flush suppresses both push and pop.
    assign push = valid_inst && !full  && !take_branch;
    assign pop  = !empty     && !id_stall && !take_branch;

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (take_branch) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupling FIFO between fetch and decode. Each fetched instruction
// {PC, PC+4, IR} is captured into a circular buffer and the oldest entry is
// presented to decode. Fetch is stalled while the queue is full, and a taken
// branch from execute discards every queued (wrong-path) instruction.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   if_PC_in/NPC_in/IR_in: fetched instruction fields
//   if_valid_inst_in     : fetch output is a real instruction
//   ex_take_branch_in    : taken branch resolved this cycle (flush)
//   id_stall_in          : decode cannot consume this cycle
//   if_stall_out         : queue full; fetch must hold its PC
//   id_PC/NPC/IR_out     : head entry fields (0 / NOOP_INST when empty)
//   id_valid_inst_out    : head entry is valid
//   fq_count_out         : current occupancy
module if_fetch_queue
    import sys_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              if_PC_in,
    input  logic [31:0]              if_NPC_in,
    input  logic [31:0]              if_IR_in,
    input  logic                     if_valid_inst_in,
    input  logic                     ex_take_branch_in,
    input  logic                     id_stall_in,
    output logic                     if_stall_out,
    output logic [31:0]              id_PC_out,
    output logic [31:0]              id_NPC_out,
    output logic [31:0]              id_IR_out,
    output logic                     id_valid_inst_out,
    output logic [$clog2(DEPTH):0]   fq_count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    fetch_entry_t     entries [DEPTH];
    fetch_entry_t     head;

    fq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .valid_inst  (if_valid_inst_in),
        .take_branch (ex_take_branch_in),
        .id_stall    (id_stall_in),
        .push        (push),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count)
    );

    // Entry storage is deliberately not reset: stale contents are never
    // visible because the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in};
        end
    end

    assign head = entries[rd_ptr];

    // Head presentation; an empty queue shows a bubble to decode.
    always_comb begin
        id_valid_inst_out = 1'b0;
        id_PC_out         = '0;
        id_NPC_out        = '0;
        id_IR_out         = NOOP_INST;
        if (!empty) begin
            id_valid_inst_out = 1'b1;
            id_PC_out         = head.pc;
            id_NPC_out        = head.npc;
            id_IR_out         = head.ir;
        end
    end

    // The fetch stall depends only on registered occupancy, so there is no
    // combinational path from the decode stall back to fetch.
    assign if_stall_out = full;
    assign fq_count_out = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (DEPTH = 4).
module tb_if_fetch_queue;

    localparam logic [31:0] TB_NOOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] if_PC_in;
    logic [31:0] if_NPC_in;
    logic [31:0] if_IR_in;
    logic        if_valid_inst_in;
    logic        ex_take_branch_in;
    logic        id_stall_in;
    logic        if_stall_out;
    logic [31:0] id_PC_out;
    logic [31:0] id_NPC_out;
    logic [31:0] id_IR_out;
    logic        id_valid_inst_out;
    logic [2:0]  fq_count_out;

    int tests_run    = 0;
    int tests_failed = 0;

    if_fetch_queue #(
        .DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_PC_in          (if_PC_in),
        .if_NPC_in         (if_NPC_in),
        .if_IR_in          (if_IR_in),
        .if_valid_inst_in  (if_valid_inst_in),
        .ex_take_branch_in (ex_take_branch_in),
        .id_stall_in       (id_stall_in),
        .if_stall_out      (if_stall_out),
        .id_PC_out         (id_PC_out),
        .id_NPC_out        (id_NPC_out),
        .id_IR_out         (id_IR_out),
        .id_valid_inst_out (id_valid_inst_out),
        .fq_count_out      (fq_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench attaches to each PC.
    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Drive one cycle of inputs at the falling edge, let the rising edge act,
    // and return at the next falling edge where outputs are sampled.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic br, input logic st);
        if_valid_inst_in  = v;
        if_PC_in          = pc;
        if_NPC_in         = pc + 32'd4;
        if_IR_in          = ir_of(pc);
        ex_take_branch_in = br;
        id_stall_in       = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if (fq_count_out !== 3'd0 || id_valid_inst_out !== 1'b0 || if_stall_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: count=%0d valid=%b stall=%b, required 0/0/0",
                     fq_count_out, id_valid_inst_out, if_stall_out);
        end
        tests_run++;
        if (id_IR_out !== TB_NOOP || id_PC_out !== 32'h0 || id_NPC_out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_head: IR=%h PC=%h NPC=%h, required %h/0/0",
                     id_IR_out, id_PC_out, id_NPC_out, TB_NOOP);
        end
        rst = 1'b0;
        step(1'b1, 32'h4, 1'b0, 1'b1);
        step(1'b1, 32'h8, 1'b0, 1'b1);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        tests_run++;
        if (fq_count_out !== 3'd3 || id_PC_out !== 32'h4) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_fill: count=%0d head=%h, required 3/00000004",
                     fq_count_out, id_PC_out);
        end
        // Asynchronous reset in the middle of the low phase.
        if_valid_inst_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (fq_count_out !== 3'd0 || id_valid_inst_out !== 1'b0 || id_IR_out !== TB_NOOP) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: count=%0d valid=%b IR=%h, required 0/0/%h",
                     fq_count_out, id_valid_inst_out, id_IR_out, TB_NOOP);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        tests_run++;
        if (id_PC_out !== 32'h40 || id_NPC_out !== 32'h44 || id_IR_out !== ir_of(32'h40)
            || id_valid_inst_out !== 1'b1 || fq_count_out !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL push_after_reset: PC=%h NPC=%h IR=%h valid=%b count=%0d, required 40/44/%h/1/1",
                     id_PC_out, id_NPC_out, id_IR_out, id_valid_inst_out, fq_count_out, ir_of(32'h40));
        end
    endtask

    task automatic test_fill();
        logic [2:0] exp_cnt [4];
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4};
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (if_stall_out !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL fill_stall_before_%0d: stall=%b, required 0", i, if_stall_out);
            end
            step(1'b1, 32'(i * 4), 1'b0, 1'b1);
            tests_run++;
            if (fq_count_out !== exp_cnt[i]) begin
                tests_failed++;
                $display("[TB] FAIL fill_count_%0d: count=%0d, required %0d", i, fq_count_out, exp_cnt[i]);
            end
        end
        tests_run++;
        if (if_stall_out !== 1'b1 || id_PC_out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL full_stall: stall=%b head=%h, required 1/00000000", if_stall_out, id_PC_out);
        end
        step(1'b1, 32'h10, 1'b0, 1'b1);
        tests_run++;
        if (fq_count_out !== 3'd4 || id_PC_out !== 32'h0 || if_stall_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL push_when_full: count=%0d head=%h stall=%b, required 4/00000000/1",
                     fq_count_out, id_PC_out, if_stall_out);
        end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] din      [5];
        logic [31:0] exp_head [5];
        logic        exp_stl  [5];
        // First edge pops from full and refuses 0x10; fetch re-presents it.
        din      = '{32'h10, 32'h10, 32'h14, 32'h18, 32'h1C};
        exp_head = '{32'h4,  32'h8,  32'hC,  32'h10, 32'h14};
        exp_stl  = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, din[i], 1'b0, 1'b0);
            tests_run++;
            if (id_PC_out !== exp_head[i] || id_IR_out !== ir_of(exp_head[i])
                || fq_count_out !== 3'd3 || if_stall_out !== exp_stl[i]) begin
                tests_failed++;
                $display("[TB] FAIL drain_%0d: head=%h IR=%h count=%0d stall=%b, required %h/%h/3/%b",
                         i, id_PC_out, id_IR_out, fq_count_out, if_stall_out,
                         exp_head[i], ir_of(exp_head[i]), exp_stl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Queue holds 0x14, 0x18, 0x1C. Pop only, then push+pop together.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if (fq_count_out !== 3'd2 || id_PC_out !== 32'h18) begin
            tests_failed++;
            $display("[TB] FAIL pop_only: count=%0d head=%h, required 2/00000018", fq_count_out, id_PC_out);
        end
        step(1'b1, 32'h20, 1'b0, 1'b0);
        tests_run++;
        if (fq_count_out !== 3'd2 || id_PC_out !== 32'h1C || id_NPC_out !== 32'h20) begin
            tests_failed++;
            $display("[TB] FAIL push_pop: count=%0d head=%h npc=%h, required 2/0000001c/00000020",
                     fq_count_out, id_PC_out, id_NPC_out);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if (fq_count_out !== 3'd2 || id_PC_out !== 32'h1C) begin
            tests_failed++;
            $display("[TB] FAIL decode_stall_hold: count=%0d head=%h, required 2/0000001c",
                     fq_count_out, id_PC_out);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h4, 1'b0, 1'b1);
        step(1'b1, 32'h8, 1'b0, 1'b1);
        tests_run++;
        if (fq_count_out !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL flush_setup: count=%0d, required 3", fq_count_out);
        end
        step(1'b1, 32'h20, 1'b1, 1'b0);
        tests_run++;
        if (fq_count_out !== 3'd0 || id_valid_inst_out !== 1'b0 || id_IR_out !== TB_NOOP
            || id_PC_out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty: count=%0d valid=%b IR=%h PC=%h, required 0/0/%h/0",
                     fq_count_out, id_valid_inst_out, id_IR_out, id_PC_out, TB_NOOP);
        end
        step(1'b1, 32'h100, 1'b0, 1'b1);
        tests_run++;
        if (id_PC_out !== 32'h100 || id_IR_out !== ir_of(32'h100) || fq_count_out !== 3'd1
            || id_valid_inst_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_target: head=%h IR=%h count=%0d valid=%b, required 00000100/%h/1/1",
                     id_PC_out, id_IR_out, fq_count_out, id_valid_inst_out, ir_of(32'h100));
        end
    endtask

    task automatic test_flush_full();
        step(1'b1, 32'h104, 1'b0, 1'b1);
        step(1'b1, 32'h108, 1'b0, 1'b1);
        step(1'b1, 32'h10C, 1'b0, 1'b1);
        tests_run++;
        if (if_stall_out !== 1'b1 || fq_count_out !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL flush_full_setup: stall=%b count=%0d, required 1/4", if_stall_out, fq_count_out);
        end
        step(1'b1, 32'h110, 1'b1, 1'b1);
        tests_run++;
        if (if_stall_out !== 1'b0 || fq_count_out !== 3'd0 || id_valid_inst_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_full: stall=%b count=%0d valid=%b, required 0/0/0",
                     if_stall_out, fq_count_out, id_valid_inst_out);
        end
    endtask

    initial begin
        rst               = 1'b1;
        if_PC_in          = '0;
        if_NPC_in         = '0;
        if_IR_in          = '0;
        if_valid_inst_in  = 1'b0;
        ex_take_branch_in = 1'b0;
        id_stall_in       = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_flush_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
